dram_bank_model: RTL and testbench

DRAM_BANK_MODEL -- requirements
Module: dram_bank_model

---
 rtl/dram_pkg.sv | 46 ++++
 rtl/dram_bank_tracker.sv | 52 +++++
 rtl/dram_bank_model.sv | 243 ++++++++++++++++++++++++
 tb/tb_dram_bank_model.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM bank model: the command set decoded from
// the strobe pins, the burst sequencer states and the BL/CL legality rules.
package dram_pkg;

    typedef enum logic [2:0] {
        NOP,
        ACT,
        RD,
        WR,
        PRE
    } cmd_t;

    typedef enum logic {
        ST_IDLE,
        ST_BURST
    } burst_state_t;

    localparam int CL_MIN = 2;
    localparam int CL_MAX = 8;

    function automatic logic bl_legal(input int bl);
        return (bl == 1) || (bl == 2) || (bl == 4) || (bl == 8);
    endfunction

    function automatic logic cl_legal(input int cl);
        return (cl >= CL_MIN) && (cl <= CL_MAX);
    endfunction

    // we_none is the AND of all active-low byte enables: with CASn low it
    // separates a read (no byte enabled) from a write.
    function automatic cmd_t decode_cmd(input logic csn, input logic rasn,
                                        input logic casn, input logic we_none);
        cmd_t c;
        c = NOP;
        if (!csn) begin
            case ({rasn, casn})
                2'b01:   c = ACT;
                2'b10:   c = we_none ? RD : WR;
                2'b00:   c = PRE;
                default: c = NOP;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/dram_bank_tracker.sv
// Per-bank open/closed flags and open-row registers.
// Ports:
//   CK, RST   clock, synchronous active-high reset (closes every bank)
//   act_en    open bank ba at row act_row
//   pre_en    close bank ba, or all banks when pre_all is set
//   ba        bank used for both update and lookup
//   bank_open / open_row   lookup result for ba
module dram_bank_tracker #(
    parameter int ROW_W  = 8,
    parameter int BANK_W = 2
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              act_en,
    input  logic              pre_en,
    input  logic              pre_all,
    input  logic [BANK_W-1:0] ba,
    input  logic [ROW_W-1:0]  act_row,
    output logic              bank_open,
    output logic [ROW_W-1:0]  open_row
);
    localparam int NB = 1 << BANK_W;

    logic [NB-1:0]    open_q;
    logic [ROW_W-1:0] row_q [NB];

    always_ff @(posedge CK) begin
        if (RST) begin
            open_q <= '0;
        end else if (act_en) begin
            open_q[ba] <= 1'b1;
        end else if (pre_en) begin
            if (pre_all) begin
                open_q <= '0;
            end else begin
                open_q[ba] <= 1'b0;
            end
        end
    end

    // Row registers are only meaningful while the open flag is set, so they
    // carry no reset.
    always_ff @(posedge CK) begin
        if (act_en) begin
            row_q[ba] <= act_row;
        end
    end

    assign bank_open = open_q[ba];
    assign open_row  = row_q[ba];

endmodule

// File: rtl/dram_bank_model.sv
// Cycle-level model of a multi-bank DRAM with ACT/RD/WR/PRE commands,
// wrapping bursts, per-byte write masks and a CAS-latency read pipeline.
// Ports:
//   CK, RST              clock, synchronous active-high reset
//   CSn, RASn, CASn, WEn command strobes (WEn doubles as byte write enable)
//   BA, A                bank and row/column address; A MSB = precharge-all
//   D                    write data, sampled on each write beat
//   Q, QVALID            read data (0 when not valid) and its valid flag
//   BUSY                 high on beats 1..BL-1 of an accepted burst
//   ERR                  one-cycle pulse, registered, after a bad command
//
// Burst sequencer states:
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | no burst in flight; RD/WR to an open bank is accepted
//   ST_BURST | beats 1..BL-1 in progress; beats_left counts down to 1
module dram_bank_model
    import dram_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ROW_W  = 8,
    parameter int COL_W  = 8,
    parameter int BANK_W = 2,
    parameter int BL     = 4,
    parameter int CL     = 2,
    localparam int BYTES  = WORD_W / 8,
    localparam int ADDR_W = ((ROW_W > COL_W) ? ROW_W : COL_W) + 1
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              CSn,
    input  logic              RASn,
    input  logic              CASn,
    input  logic [BYTES-1:0]  WEn,
    input  logic [BANK_W-1:0] BA,
    input  logic [ADDR_W-1:0] A,
    input  logic [WORD_W-1:0] D,
    output logic [WORD_W-1:0] Q,
    output logic              QVALID,
    output logic              BUSY,
    output logic              ERR
);
    localparam int MEM_AW    = BANK_W + ROW_W + COL_W;
    localparam int MEM_WORDS = 1 << MEM_AW;
    localparam int CNT_W     = $clog2(BL) + 1;
    localparam logic [COL_W-1:0] BEAT_MASK = COL_W'(BL - 1);

    if (!bl_legal(BL)) begin : g_bad_bl
        $error("dram_bank_model: BL must be 1, 2, 4 or 8");
    end
    if (!cl_legal(CL)) begin : g_bad_cl
        $error("dram_bank_model: CL out of range");
    end
    if ((WORD_W % 8) != 0) begin : g_bad_word
        $error("dram_bank_model: WORD_W must be a multiple of 8");
    end

    cmd_t             cmd;
    logic             pre_all;
    logic             bank_open;
    logic [ROW_W-1:0] open_row;
    logic             act_en;
    logic             pre_en;
    logic             col_cmd;
    logic             start;
    logic             hits_burst;
    logic             err_d;

    burst_state_t     state;
    burst_state_t     state_nx;
    logic             busy;
    logic [CNT_W-1:0] beats_left;

    logic              b_wr;
    logic [BANK_W-1:0] b_bank;
    logic [ROW_W-1:0]  b_row;
    logic [COL_W-1:0]  b_col;
    logic [BYTES-1:0]  b_mask;
    logic [COL_W-1:0]  beat_idx;
    logic [COL_W-1:0]  beat_col;

    logic              acc_en;
    logic              acc_wr;
    logic [MEM_AW-1:0] acc_addr;
    logic [BYTES-1:0]  acc_mask;
    logic              acc_we;
    logic              acc_rd;

    logic [WORD_W-1:0] mem [MEM_WORDS];
    logic [CL-1:0]     pipe_v;
    logic [WORD_W-1:0] pipe_d [CL];

    assign cmd     = decode_cmd(CSn, RASn, CASn, &WEn);
    assign pre_all = A[ADDR_W-1];

    dram_bank_tracker #(
        .ROW_W  (ROW_W),
        .BANK_W (BANK_W)
    ) u_tracker (
        .CK        (CK),
        .RST       (RST),
        .act_en    (act_en),
        .pre_en    (pre_en),
        .pre_all   (pre_all),
        .ba        (BA),
        .act_row   (A[ROW_W-1:0]),
        .bank_open (bank_open),
        .open_row  (open_row)
    );

    // Command acceptance and protocol checks.
    always_comb begin
        col_cmd    = (cmd == RD) || (cmd == WR);
        hits_burst = busy && (pre_all || (BA == b_bank));
        act_en     = (cmd == ACT) && !bank_open;
        pre_en     = (cmd == PRE) && !hits_burst;
        start      = col_cmd && !busy && bank_open;
        err_d      = ((cmd == ACT) && bank_open)
                   || (col_cmd && (busy || !bank_open))
                   || ((cmd == PRE) && hits_burst);
    end

    // ---- burst sequencer FSM ----
    always_ff @(posedge CK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (start && (BL != 1)) begin
                    state_nx = ST_BURST;
                end
            end
            ST_BURST: begin
                if (beats_left == CNT_W'(1)) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ST_BURST);
        BUSY = busy;
    end

    // Burst context captured on the command cycle; beat 0 runs on that same
    // cycle straight from the pins, so the counter only covers beats 1..BL-1.
    always_ff @(posedge CK) begin
        if (RST) begin
            beats_left <= '0;
            b_wr       <= 1'b0;
            b_bank     <= '0;
            b_row      <= '0;
            b_col      <= '0;
            b_mask     <= '0;
        end else if (start) begin
            beats_left <= CNT_W'(BL - 1);
            b_wr       <= (cmd == WR);
            b_bank     <= BA;
            b_row      <= open_row;
            b_col      <= A[COL_W-1:0];
            b_mask     <= ~WEn;
        end else if (busy) begin
            beats_left <= beats_left - CNT_W'(1);
        end
    end

    // Beat k column: keep the aligned block, wrap the low bits modulo BL.
    always_comb begin
        beat_idx = COL_W'(BL) - COL_W'(beats_left);
        beat_col = (b_col & ~BEAT_MASK) | ((b_col + beat_idx) & BEAT_MASK);
    end

    always_comb begin
        acc_en   = 1'b0;
        acc_wr   = 1'b0;
        acc_addr = '0;
        acc_mask = '0;
        if (start) begin
            acc_en   = 1'b1;
            acc_wr   = (cmd == WR);
            acc_addr = {BA, open_row, A[COL_W-1:0]};
            acc_mask = ~WEn;
        end else if (busy) begin
            acc_en   = 1'b1;
            acc_wr   = b_wr;
            acc_addr = {b_bank, b_row, beat_col};
            acc_mask = b_mask;
        end
        acc_we = acc_en && acc_wr && !RST;
        acc_rd = acc_en && !acc_wr && !RST;
    end

    // Array contents survive reset.
    always_ff @(posedge CK) begin
        if (acc_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (acc_mask[b]) begin
                    mem[acc_addr][b*8 +: 8] <= D[b*8 +: 8];
                end
            end
        end
    end

    // Stage 0 is the array read itself, so the last of CL stages lands
    // exactly CL cycles after the beat's array cycle. Invalid slots carry
    // zero data, which keeps Q at 0 whenever QVALID is low.
    always_ff @(posedge CK) begin
        if (RST) begin
            pipe_v <= '0;
            for (int i = 0; i < CL; i++) begin
                pipe_d[i] <= '0;
            end
        end else begin
            pipe_v[0] <= acc_rd;
            pipe_d[0] <= acc_rd ? mem[acc_addr] : '0;
            for (int i = 1; i < CL; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    assign QVALID = pipe_v[CL-1];
    assign Q      = pipe_d[CL-1];

    always_ff @(posedge CK) begin
        if (RST) begin
            ERR <= 1'b0;
        end else begin
            ERR <= err_d;
        end
    end

endmodule

// File: tb/tb_dram_bank_model.sv
module tb_dram_bank_model;

    localparam int WORD_W = 32;
    localparam int ROW_W  = 8;
    localparam int COL_W  = 8;
    localparam int BANK_W = 2;
    localparam int BL     = 4;
    localparam int CL     = 2;
    localparam int BYTES  = WORD_W / 8;
    localparam int ADDR_W = 9;

    logic              CK = 1'b0;
    logic              RST;
    logic              CSn;
    logic              RASn;
    logic              CASn;
    logic [BYTES-1:0]  WEn;
    logic [BANK_W-1:0] BA;
    logic [ADDR_W-1:0] A;
    logic [WORD_W-1:0] D;
    logic [WORD_W-1:0] Q;
    logic              QVALID;
    logic              BUSY;
    logic              ERR;

    int n_vec = 0;
    int n_err = 0;

    dram_bank_model #(
        .WORD_W (WORD_W),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W),
        .BANK_W (BANK_W),
        .BL     (BL),
        .CL     (CL)
    ) dut (
        .CK     (CK),
        .RST    (RST),
        .CSn    (CSn),
        .RASn   (RASn),
        .CASn   (CASn),
        .WEn    (WEn),
        .BA     (BA),
        .A      (A),
        .D      (D),
        .Q      (Q),
        .QVALID (QVALID),
        .BUSY   (BUSY),
        .ERR    (ERR)
    );

    always #5 CK = ~CK;

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_q(input string tag, input logic v, input logic [31:0] q);
        chk({tag, "_qvalid"}, {31'd0, QVALID}, {31'd0, v});
        chk({tag, "_q"}, Q, q);
    endtask

    task automatic nop();
        CSn = 1'b1; RASn = 1'b1; CASn = 1'b1; WEn = '1; BA = '0; A = '0;
    endtask

    task automatic act(input int b, input int row);
        CSn = 1'b0; RASn = 1'b0; CASn = 1'b1; WEn = '1;
        BA = BANK_W'(b); A = ADDR_W'(row);
    endtask

    task automatic rd(input int b, input int col);
        CSn = 1'b0; RASn = 1'b1; CASn = 1'b0; WEn = '1;
        BA = BANK_W'(b); A = ADDR_W'(col);
    endtask

    task automatic wr(input int b, input int col, input logic [3:0] we_n, input logic [31:0] d);
        CSn = 1'b0; RASn = 1'b1; CASn = 1'b0; WEn = we_n;
        BA = BANK_W'(b); A = ADDR_W'(col); D = d;
    endtask

    task automatic pre(input int b, input logic all);
        CSn = 1'b0; RASn = 1'b0; CASn = 1'b0; WEn = '1;
        BA = BANK_W'(b); A = {all, 8'd0};
    endtask

    initial begin
        RST = 1'b1; D = '0;
        nop();
        step();
        step();
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_err", {31'd0, ERR}, 32'd0);
        chk_q("rst", 1'b0, 32'h0);
        RST = 1'b0;

        // Open bank 0 row 5, write 11/22/33/44 to cols 0..3.
        act(0, 5);
        step();
        chk("act_err", {31'd0, ERR}, 32'd0);
        wr(0, 0, 4'b0000, 32'h11);
        step();
        chk("wr_busy1", {31'd0, BUSY}, 32'd1);
        nop(); D = 32'h22;
        step();
        chk("wr_busy2", {31'd0, BUSY}, 32'd1);
        D = 32'h33;
        step();
        chk("wr_busy3", {31'd0, BUSY}, 32'd1);
        D = 32'h44;
        step();
        chk("wr_busy_end", {31'd0, BUSY}, 32'd0);

        // Read col 0: data CL=2 cycles after the command.
        rd(0, 0);
        step();
        chk_q("rd0_c1", 1'b0, 32'h0);
        chk("rd0_busy", {31'd0, BUSY}, 32'd1);
        nop();
        step(); chk_q("rd0_b0", 1'b1, 32'h11);
        step(); chk_q("rd0_b1", 1'b1, 32'h22);
        step(); chk_q("rd0_b2", 1'b1, 32'h33);
        step(); chk_q("rd0_b3", 1'b1, 32'h44);
        step(); chk_q("rd0_end", 1'b0, 32'h0);

        // Wrapping read at col 2, illegal RD mid-burst, then back-to-back RD col 1.
        rd(0, 2);
        step(); chk_q("wrap_c1", 1'b0, 32'h0);
        nop();
        step(); chk_q("wrap_b0", 1'b1, 32'h33);
        rd(0, 3);
        step(); chk_q("wrap_b1", 1'b1, 32'h44);
        chk("busy_rd_err", {31'd0, ERR}, 32'd1);
        nop();
        step(); chk_q("wrap_b2", 1'b1, 32'h11);
        chk("busy_rd_err_clr", {31'd0, ERR}, 32'd0);
        chk("b2b_idle", {31'd0, BUSY}, 32'd0);
        rd(0, 1);
        step(); chk_q("wrap_b3", 1'b1, 32'h22);
        nop();
        step(); chk_q("b2b_b0", 1'b1, 32'h22);
        step(); chk_q("b2b_b1", 1'b1, 32'h33);
        step(); chk_q("b2b_b2", 1'b1, 32'h44);
        step(); chk_q("b2b_b3", 1'b1, 32'h11);
        step(); chk_q("b2b_end", 1'b0, 32'h0);

        // Byte mask: clear cols 8..11, then write only byte 0 with the mask
        // held even while WEn is driven low on the following beats.
        wr(0, 8, 4'b0000, 32'h0);
        step(); nop(); step(); step(); step();
        wr(0, 8, 4'b1110, 32'hFFFF_FFFF);
        step();
        nop(); WEn = 4'b0000;
        step(); step(); step();
        nop();
        rd(0, 8);
        step(); nop();
        step(); chk_q("mask_b0", 1'b1, 32'h0000_00FF);
        step(); chk_q("mask_b1", 1'b1, 32'h0000_00FF);
        step(); chk_q("mask_b2", 1'b1, 32'h0000_00FF);
        step(); chk_q("mask_b3", 1'b1, 32'h0000_00FF);
        step();

        // Closed-bank read and double ACT.
        rd(1, 0);
        step(); chk("closed_rd_err", {31'd0, ERR}, 32'd1);
        chk("closed_rd_busy", {31'd0, BUSY}, 32'd0);
        nop();
        step(); chk_q("closed_rd_c2", 1'b0, 32'h0);
        chk("err_one_cycle", {31'd0, ERR}, 32'd0);
        step(); chk_q("closed_rd_c3", 1'b0, 32'h0);
        act(0, 9);
        step(); chk("dbl_act_err", {31'd0, ERR}, 32'd1);
        pre(2, 1'b0);
        step(); chk("pre_closed_err", {31'd0, ERR}, 32'd0);

        // Row must still be 5; PRE of bursting bank is rejected, ACT b1 is fine.
        rd(0, 0);
        step(); pre(0, 1'b0);
        step(); chk_q("rowkeep_b0", 1'b1, 32'h11);
        chk("pre_busy_err", {31'd0, ERR}, 32'd1);
        act(1, 3);
        step(); chk_q("rowkeep_b1", 1'b1, 32'h22);
        chk("act_busy_err", {31'd0, ERR}, 32'd0);
        nop();
        step(); chk_q("rowkeep_b2", 1'b1, 32'h33);
        step(); chk_q("rowkeep_b3", 1'b1, 32'h44);
        rd(1, 0);
        step(); chk("b1_open_err", {31'd0, ERR}, 32'd0);
        nop();
        step(); chk("b1_rd_qvalid", {31'd0, QVALID}, 32'd1);
        step(); step(); step(); step();

        // Reset during read beat 2.
        rd(0, 0);
        step(); nop();
        step(); chk_q("rst_mid_b0", 1'b1, 32'h11);
        RST = 1'b1;
        step();
        chk_q("rst_mid", 1'b0, 32'h0);
        chk("rst_mid_busy", {31'd0, BUSY}, 32'd0);
        RST = 1'b0;
        rd(0, 0);
        step(); chk("rst_closed_err", {31'd0, ERR}, 32'd1);
        nop();
        step(); chk_q("rst_no_data", 1'b0, 32'h0);

        // Precharge-all closes every bank.
        act(0, 5);
        step();
        act(1, 3);
        step();
        pre(2, 1'b1);
        step(); chk("preall_err", {31'd0, ERR}, 32'd0);
        rd(1, 0);
        step(); chk("preall_b1_err", {31'd0, ERR}, 32'd1);
        rd(0, 0);
        step(); chk("preall_b0_err", {31'd0, ERR}, 32'd1);

        // Array contents are not touched by reset.
        act(0, 5);
        step();
        rd(0, 1);
        step(); nop();
        step(); chk_q("keep_b0", 1'b1, 32'h22);
        step(); chk_q("keep_b1", 1'b1, 32'h33);
        step(); step();
        step(); chk_q("keep_end", 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
